// File: rtl/fpu_req_arbiter_pkg.sv
// Shared types for the FPU request arbiter: op/rounding encodings, flag positions, FSM states.
package fpu_req_arbiter_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned RM_W   = 2;
  localparam int unsigned FLAG_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 8'h80,
    OP_SUB = 8'h81,
    OP_MUL = 8'h82,
    OP_DIV = 8'h83
  } op_t;

  typedef enum logic [RM_W-1:0] {
    RM_NEAREST = 2'd0,
    RM_TO_ZERO = 2'd1,
    RM_TO_INFP = 2'd2,
    RM_TO_INFM = 2'd3
  } rmode_t;

  // Exception flag bit positions within the 5-bit flag field
  localparam int unsigned FLAG_NX = 0;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_NV = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [RM_W-1:0] rmode;
  } fpu_cmd_t;

  typedef struct packed {
    logic              err;
    logic [FLAG_W-1:0] flags;
  } rsp_meta_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_req_arbiter_if.sv
// Bundle of requester, FPU and response signals around the FPU request arbiter.
interface fpu_req_arbiter_if
  import fpu_req_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 32
);
  localparam int unsigned IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]      req_valid_i;
  logic [N_REQ-1:0]      req_ready_o;
  logic [N_REQ*OP_W-1:0] req_op_i;
  logic [N_REQ*RM_W-1:0] req_rmode_i;
  logic [N_REQ*W-1:0]    req_opa_i;
  logic [N_REQ*W-1:0]    req_opb_i;

  logic                  fpu_start_o;
  logic [OP_W-1:0]       fpu_op_o;
  logic [RM_W-1:0]       fpu_rmode_o;
  logic [W-1:0]          fpu_opa_o;
  logic [W-1:0]          fpu_opb_o;
  logic                  fpu_done_i;
  logic [W-1:0]          fpu_result_i;
  logic [FLAG_W-1:0]     fpu_flags_i;
  logic                  fpu_flush_o;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [IDW-1:0]        rsp_id_o;
  logic [W-1:0]          rsp_result_o;
  logic [FLAG_W-1:0]     rsp_flags_o;
  logic                  rsp_err_o;

  // Arbiter side
  modport slave (
    input  req_valid_i, req_op_i, req_rmode_i, req_opa_i, req_opb_i,
    input  fpu_done_i, fpu_result_i, fpu_flags_i, rsp_ready_i,
    output req_ready_o, fpu_start_o, fpu_op_o, fpu_rmode_o, fpu_opa_o, fpu_opb_o,
    output fpu_flush_o, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_flags_o, rsp_err_o
  );

  // Requesters, FPU and response consumer side
  modport master (
    output req_valid_i, req_op_i, req_rmode_i, req_opa_i, req_opb_i,
    output fpu_done_i, fpu_result_i, fpu_flags_i, rsp_ready_i,
    input  req_ready_o, fpu_start_o, fpu_op_o, fpu_rmode_o, fpu_opa_o, fpu_opb_o,
    input  fpu_flush_o, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_flags_o, rsp_err_o
  );

endinterface

// File: rtl/fpu_req_arbiter_rr_arbiter.sv
// Round-robin arbiter: first requester at or above the pointer wins, pointer moves past the winner on accept.
module fpu_req_arbiter_rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic                     accept,
  output logic [N_REQ-1:0]         grant_c,
  output logic [$clog2(N_REQ)-1:0] grant_id_c
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned SW  = IDW + 1;

  logic [IDW-1:0] ptr_q;
  logic [SW-1:0]  probe;
  logic [IDW-1:0] idx;
  logic           found;

  // Search ptr, ptr+1, ... with modulo-N_REQ wrap so non power-of-2 counts work
  always_comb begin
    grant_c    = '0;
    grant_id_c = '0;
    found      = 1'b0;
    probe      = '0;
    idx        = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      probe = SW'(ptr_q) + SW'(k);
      if (probe >= SW'(N_REQ)) probe = probe - SW'(N_REQ);
      idx = IDW'(probe);
      if (!found && req[idx]) begin
        found        = 1'b1;
        grant_c[idx] = 1'b1;
        grant_id_c   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (grant_id_c == IDW'(N_REQ - 1)) ? '0 : grant_id_c + IDW'(1);
    end
  end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Shares one FPU between N_REQ requesters, one op in flight, results tagged with requester ID.
// Define FPU_TIMEOUT_EN to enable the WAIT-state watchdog (flush + error response).
module fpu_req_arbiter
  import fpu_req_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned W           = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input logic              clk,
  input logic              rst_n,
  fpu_req_arbiter_if.slave bus
);

  localparam int unsigned IDW = $clog2(N_REQ);

  if (N_REQ < 2 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("fpu_req_arbiter: needs N_REQ >= 2 and TIMEOUT_CYC >= 1");
  end

  state_t           state_q;
  state_t           next_state;

  logic [N_REQ-1:0] grant_c;
  logic [IDW-1:0]   grant_id_c;
  logic             accept_c;
  logic             legal_c;
  logic             done_hit_c;
  logic             expire_c;
  logic             timeout_c;

  fpu_cmd_t         sel_cmd_c;
  logic [W-1:0]     sel_opa_c;
  logic [W-1:0]     sel_opb_c;

  fpu_cmd_t         cmd_q;
  logic [W-1:0]     opa_q;
  logic [W-1:0]     opb_q;
  logic             fpu_start_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [W-1:0]     rsp_result_q;
  rsp_meta_t        rsp_meta_q;

  fpu_req_arbiter_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (bus.req_valid_i),
    .accept     (accept_c),
    .grant_c    (grant_c),
    .grant_id_c (grant_id_c)
  );

  // Payload of the granted requester (grant is one-hot, so an OR-mux suffices)
  always_comb begin
    sel_cmd_c = '0;
    sel_opa_c = '0;
    sel_opb_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_c[i]) begin
        sel_cmd_c.op    = bus.req_op_i[i*OP_W +: OP_W];
        sel_cmd_c.rmode = bus.req_rmode_i[i*RM_W +: RM_W];
        sel_opa_c       = bus.req_opa_i[i*W +: W];
        sel_opb_c       = bus.req_opb_i[i*W +: W];
      end
    end
  end

  assign legal_c         = is_legal_op(sel_cmd_c.op);
  assign bus.req_ready_o = (state_q == ST_IDLE) ? grant_c : '0;

`ifdef FPU_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] wait_cnt_q;
  logic          flush_q;

  // Counts completed WAIT cycles; expiry is the TIMEOUT_CYC-th WAIT cycle without done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      flush_q    <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == ST_WAIT) ? wait_cnt_q + CW'(1) : '0;
      flush_q    <= expire_c;
    end
  end

  assign timeout_c       = (state_q == ST_WAIT) && (wait_cnt_q == CW'(TIMEOUT_CYC - 1));
  assign bus.fpu_flush_o = flush_q;
`else
  assign timeout_c       = 1'b0;
  assign bus.fpu_flush_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= next_state;
  end

  // Next state; a done in the expiry cycle takes priority over the watchdog
  always_comb begin
    next_state = state_q;
    accept_c   = 1'b0;
    done_hit_c = 1'b0;
    expire_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid_i) begin
          accept_c   = 1'b1;
          next_state = legal_c ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT: begin
        if (bus.fpu_done_i) begin
          done_hit_c = 1'b1;
          next_state = ST_RESP;
        end else if (timeout_c) begin
          expire_c   = 1'b1;
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready_i) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      fpu_start_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_meta_q   <= '0;
    end else begin
      fpu_start_q <= (next_state == ST_ISSUE);
      rsp_valid_q <= (next_state == ST_RESP);
      if (accept_c) begin
        rsp_id_q <= grant_id_c;
        // Illegal ops never reach the FPU, so its operand registers keep their last values
        if (legal_c) begin
          cmd_q <= sel_cmd_c;
          opa_q <= sel_opa_c;
          opb_q <= sel_opb_c;
        end else begin
          rsp_result_q <= '0;
          rsp_meta_q   <= '{err: 1'b1, flags: FLAG_W'(0)};
        end
      end
      if (done_hit_c) begin
        rsp_result_q <= bus.fpu_result_i;
        rsp_meta_q   <= '{err: 1'b0, flags: bus.fpu_flags_i};
      end
      if (expire_c) begin
        rsp_result_q <= '0;
        rsp_meta_q   <= '{err: 1'b1, flags: FLAG_W'(0)};
      end
    end
  end

  assign bus.fpu_start_o  = fpu_start_q;
  assign bus.fpu_op_o     = cmd_q.op;
  assign bus.fpu_rmode_o  = cmd_q.rmode;
  assign bus.fpu_opa_o    = opa_q;
  assign bus.fpu_opb_o    = opb_q;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_id_o     = rsp_id_q;
  assign bus.rsp_result_o = rsp_result_q;
  assign bus.rsp_flags_o  = rsp_meta_q.flags;
  assign bus.rsp_err_o    = rsp_meta_q.err;

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed bench for fpu_req_arbiter: latency, round-robin order, illegal op, backpressure, reset abort, watchdog.
module tb_fpu_req_arbiter;
  import fpu_req_arbiter_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;
`ifdef FPU_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 64;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   n_start = 0;
  int   s0;

  fpu_req_arbiter_if #(.N_REQ(N), .W(W)) bus ();

  fpu_req_arbiter #(.N_REQ(N), .W(W), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.fpu_start_o === 1'b1) n_start <= n_start + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [7:0] op, input logic [1:0] rm,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_op_i[id*8 +: 8]    = op;
    bus.req_rmode_i[id*2 +: 2] = rm;
    bus.req_opa_i[id*W +: W]   = a;
    bus.req_opb_i[id*W +: W]   = b;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".start"},  64'(bus.fpu_start_o),  64'h0);
    chk({tag, ".op"},     64'(bus.fpu_op_o),     64'h0);
    chk({tag, ".rmode"},  64'(bus.fpu_rmode_o),  64'h0);
    chk({tag, ".opa"},    64'(bus.fpu_opa_o),    64'h0);
    chk({tag, ".opb"},    64'(bus.fpu_opb_o),    64'h0);
    chk({tag, ".flush"},  64'(bus.fpu_flush_o),  64'h0);
    chk({tag, ".rvalid"}, 64'(bus.rsp_valid_o),  64'h0);
    chk({tag, ".rid"},    64'(bus.rsp_id_o),     64'h0);
    chk({tag, ".rres"},   64'(bus.rsp_result_o), 64'h0);
    chk({tag, ".rflags"}, 64'(bus.rsp_flags_o),  64'h0);
    chk({tag, ".rerr"},   64'(bus.rsp_err_o),    64'h0);
  endtask

  task automatic rsp_accept();
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n            = 1'b0;
    bus.req_valid_i  = '0;
    bus.req_op_i     = '0;
    bus.req_rmode_i  = '0;
    bus.req_opa_i    = '0;
    bus.req_opb_i    = '0;
    bus.fpu_done_i   = 1'b0;
    bus.fpu_result_i = '0;
    bus.fpu_flags_i  = '0;
    bus.rsp_ready_i  = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    chk("reset.ready", 64'(bus.req_ready_o), 64'h0);
    rst_n = 1'b1;

    // 1: single ADD from requester 2, minimum latency
    set_req(2, OP_ADD, RM_NEAREST, 32'h3f80_0000, 32'h4000_0000);
    bus.req_valid_i = 4'b0100;
    #1 chk("t1.ready_c0", 64'(bus.req_ready_o), 64'b0100);
    tick();
    bus.req_valid_i = '0;
    chk("t1.start_c1", 64'(bus.fpu_start_o), 64'h1);
    chk("t1.op",       64'(bus.fpu_op_o),    64'h80);
    chk("t1.rmode",    64'(bus.fpu_rmode_o), 64'h0);
    chk("t1.opa",      64'(bus.fpu_opa_o),   64'h3f80_0000);
    chk("t1.opb",      64'(bus.fpu_opb_o),   64'h4000_0000);
    chk("t1.ready_c1", 64'(bus.req_ready_o), 64'h0);
    tick();
    chk("t1.start_c2",  64'(bus.fpu_start_o), 64'h0);
    chk("t1.op_held",   64'(bus.fpu_op_o),    64'h80);
    chk("t1.rvalid_c2", 64'(bus.rsp_valid_o), 64'h0);
    bus.fpu_done_i   = 1'b1;
    bus.fpu_result_i = 32'h4040_0000;
    bus.fpu_flags_i  = '0;
    tick();
    bus.fpu_done_i = 1'b0;
    chk("t1.rvalid_c3", 64'(bus.rsp_valid_o),  64'h1);
    chk("t1.rid",       64'(bus.rsp_id_o),     64'h2);
    chk("t1.rres",      64'(bus.rsp_result_o), 64'h4040_0000);
    chk("t1.rerr",      64'(bus.rsp_err_o),    64'h0);
    chk("t1.rflags",    64'(bus.rsp_flags_o),  64'h0);
    rsp_accept();
    chk("t1.rvalid_c4", 64'(bus.rsp_valid_o), 64'h0);

    // 2: all four valid from reset -> grant order 0,1,2,3,0
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, OP_ADD, RM_NEAREST, 32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i));
    bus.req_valid_i = 4'hF;
    tick();
    tick();
    rst_n = 1'b1;
    chk("t2.rvalid_rst", 64'(bus.rsp_valid_o), 64'h0);
    s0 = n_start;
    for (int k = 0; k < 5; k++) begin
      int id;
      id = k % 4;
      #1 chk($sformatf("t2.ready_%0d", k), 64'(bus.req_ready_o), 64'(1) << id);
      tick();
      chk($sformatf("t2.start_%0d", k), 64'(bus.fpu_start_o), 64'h1);
      chk($sformatf("t2.opa_%0d", k),   64'(bus.fpu_opa_o),   64'h1000_0000 + 64'(id));
      tick();
      bus.fpu_done_i   = 1'b1;
      bus.fpu_result_i = 32'hA000_0000 + 32'(id);
      bus.fpu_flags_i  = 5'(id);
      tick();
      bus.fpu_done_i = 1'b0;
      chk($sformatf("t2.rvalid_%0d", k), 64'(bus.rsp_valid_o),  64'h1);
      chk($sformatf("t2.rid_%0d", k),    64'(bus.rsp_id_o),     64'(id));
      chk($sformatf("t2.rres_%0d", k),   64'(bus.rsp_result_o), 64'hA000_0000 + 64'(id));
      chk($sformatf("t2.rflag_%0d", k),  64'(bus.rsp_flags_o),  64'(id));
      rsp_accept();
    end
    chk("t2.starts", 64'(n_start - s0), 64'd5);

    // 3: illegal op from requester 1 (pointer now at 1)
    bus.req_valid_i = 4'b0010;
    set_req(1, 8'h90, RM_NEAREST, 32'h5, 32'h6);
    s0 = n_start;
    #1 chk("t3.ready", 64'(bus.req_ready_o), 64'b0010);
    tick();
    bus.req_valid_i = '0;
    chk("t3.rvalid", 64'(bus.rsp_valid_o),  64'h1);
    chk("t3.rerr",   64'(bus.rsp_err_o),    64'h1);
    chk("t3.rres",   64'(bus.rsp_result_o), 64'h0);
    chk("t3.rflags", 64'(bus.rsp_flags_o),  64'h0);
    chk("t3.rid",    64'(bus.rsp_id_o),     64'h1);
    chk("t3.start",  64'(bus.fpu_start_o),  64'h0);
    rsp_accept();
    chk("t3.nostart", 64'(n_start - s0), 64'd0);

    // 4: MUL from requester 3, response held 5 cycles while requester 0 waits
    bus.req_valid_i = 4'b1000;
    set_req(3, OP_MUL, RM_TO_ZERO, 32'h4000_0000, 32'h4040_0000);
    s0 = n_start;
    #1 chk("t4.ready", 64'(bus.req_ready_o), 64'b1000);
    tick();
    bus.req_valid_i = 4'b0001;
    set_req(0, OP_DIV, RM_TO_INFP, 32'h4120_0000, 32'h4000_0000);
    chk("t4.start", 64'(bus.fpu_start_o), 64'h1);
    chk("t4.op",    64'(bus.fpu_op_o),    64'h82);
    chk("t4.rmode", 64'(bus.fpu_rmode_o), 64'h1);
    #1 chk("t4.ready_busy", 64'(bus.req_ready_o), 64'h0);
    tick();
    bus.fpu_done_i   = 1'b1;
    bus.fpu_result_i = 32'h40C0_0000;
    bus.fpu_flags_i  = 5'(1) << FLAG_NX;
    tick();
    bus.fpu_done_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t4.rvalid_%0d", c), 64'(bus.rsp_valid_o),  64'h1);
      chk($sformatf("t4.rres_%0d", c),   64'(bus.rsp_result_o), 64'h40C0_0000);
      chk($sformatf("t4.rid_%0d", c),    64'(bus.rsp_id_o),     64'h3);
      chk($sformatf("t4.rflag_%0d", c),  64'(bus.rsp_flags_o),  64'h1);
      chk($sformatf("t4.ready_%0d", c),  64'(bus.req_ready_o),  64'h0);
      tick();
    end
    chk("t4.one_start", 64'(n_start - s0), 64'd1);
    rsp_accept();
    #1 chk("t4.next_grant", 64'(bus.req_ready_o), 64'b0001);

    // 5: reset during WAIT, late done ignored
    s0 = n_start;
    tick();
    bus.req_valid_i = '0;
    chk("t5.start", 64'(bus.fpu_start_o), 64'h1);
    chk("t5.op",    64'(bus.fpu_op_o),    64'h83);
    tick();
    chk("t5.wait", 64'(bus.fpu_start_o), 64'h0);
    rst_n = 1'b0;
    #1 chk_all_zero("t5.rst");
    chk("t5.ready_rst", 64'(bus.req_ready_o), 64'h0);
    tick();
    rst_n            = 1'b1;
    bus.fpu_done_i   = 1'b1;
    bus.fpu_result_i = 32'hDEAD_BEEF;
    tick();
    bus.fpu_done_i = 1'b0;
    chk("t5.no_rsp0", 64'(bus.rsp_valid_o), 64'h0);
    tick();
    chk("t5.no_rsp1",  64'(bus.rsp_valid_o),  64'h0);
    chk("t5.rres",     64'(bus.rsp_result_o), 64'h0);
    chk("t5.starts",   64'(n_start - s0),     64'd1);
    bus.req_valid_i = 4'b1010;
    #1 chk("t5.idle_ptr0", 64'(bus.req_ready_o), 64'b0010);
    bus.req_valid_i = '0;
    tick();

`ifdef FPU_TIMEOUT_EN
    // 6: watchdog expiry after 8 WAIT cycles, then done-in-expiry-cycle wins
    bus.req_valid_i = 4'b0100;
    set_req(2, OP_ADD, RM_TO_INFM, 32'h1, 32'h2);
    #1 chk("t6.ready", 64'(bus.req_ready_o), 64'b0100);
    tick();
    bus.req_valid_i = '0;
    chk("t6.start", 64'(bus.fpu_start_o), 64'h1);
    tick();
    for (int w = 0; w < 8; w++) begin
      chk($sformatf("t6.noflush_%0d", w), 64'(bus.fpu_flush_o), 64'h0);
      chk($sformatf("t6.norsp_%0d", w),   64'(bus.rsp_valid_o), 64'h0);
      tick();
    end
    chk("t6.flush",  64'(bus.fpu_flush_o),  64'h1);
    chk("t6.rvalid", 64'(bus.rsp_valid_o),  64'h1);
    chk("t6.rerr",   64'(bus.rsp_err_o),    64'h1);
    chk("t6.rres",   64'(bus.rsp_result_o), 64'h0);
    chk("t6.rflags", 64'(bus.rsp_flags_o),  64'h0);
    chk("t6.rid",    64'(bus.rsp_id_o),     64'h2);
    tick();
    chk("t6.flush_once", 64'(bus.fpu_flush_o), 64'h0);
    chk("t6.rvalid_hold", 64'(bus.rsp_valid_o), 64'h1);
    rsp_accept();
    bus.req_valid_i = 4'b0010;
    set_req(1, OP_SUB, RM_NEAREST, 32'h3, 32'h4);
    #1 chk("t6b.ready", 64'(bus.req_ready_o), 64'b0010);
    tick();
    bus.req_valid_i = '0;
    tick();
    repeat (7) tick();
    bus.fpu_done_i   = 1'b1;
    bus.fpu_result_i = 32'h3f80_0000;
    bus.fpu_flags_i  = '0;
    tick();
    bus.fpu_done_i = 1'b0;
    chk("t6b.rvalid", 64'(bus.rsp_valid_o),  64'h1);
    chk("t6b.rerr",   64'(bus.rsp_err_o),    64'h0);
    chk("t6b.rres",   64'(bus.rsp_result_o), 64'h3f80_0000);
    chk("t6b.flush",  64'(bus.fpu_flush_o),  64'h0);
    rsp_accept();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
